mem_sweep_ram: RTL

- Parametrised successor to the team's basic synchronous RAM.
- Single-port RAM with configurable width and depth, a valid/ready request interface, and a registered read response.
- Built-in clear sequencer fills every word with a fill value after reset and on demand.
- Sits between a controller/CPU datapath and storage. Callers never see uninitialised contents.

---
 rtl/mem_sweep_ram_if.sv | 26 ++
 rtl/mem_sweep_ram.sv | 78 +++++++
 2 files changed

// File: rtl/mem_sweep_ram_if.sv
// Request/response bundle for mem_sweep_ram: valid/ready request channel,
// clear/busy sweep control and the registered read response.
interface mem_sweep_ram_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             clear;
  logic             busy;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clear,
    input  req_ready, busy, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clear,
    output req_ready, busy, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_sweep_ram.sv
// Single-port RAM with valid/ready requests, 1-cycle registered read response
// and a clear sequencer that fills every word with FILL after reset / on clear.
module mem_sweep_ram #(
  parameter int               WIDTH = 4,
  parameter int               AW    = 4,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic            clk,
  input  logic            reset,
  mem_sweep_ram_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t           state_q;
  logic [AW-1:0]    ptr_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic             mem_we_d;
  logic [AW-1:0]    mem_waddr_d;
  logic [WIDTH-1:0] mem_wdata_d;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // Single write port shared by the sweep and caller writes; reset blocks it.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = ptr_q;
    mem_wdata_d = FILL;
    if (!reset) begin
      if (state_q == SWEEP) begin
        mem_we_d = 1'b1;
      end else if (accept && bus.req_we) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = bus.req_addr;
        mem_wdata_d = bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SWEEP;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        SWEEP: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH - 1)) state_q <= IDLE;
        end
        default: begin
          if (accept && !bus.req_we) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mem_q[bus.req_addr];
          end
          // A request in the same cycle as clear still executes on pre-clear data.
          if (bus.clear) state_q <= SWEEP;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q == SWEEP);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule
